// File: rtl/dma_dreq_agent_if.sv
// DMA channel pins (DREQ/DACK/strobes/data) and the local byte-stream handshakes.
// slave is the peripheral agent; master is the DMA controller plus local datapath.
interface dma_dreq_agent_if;
  logic       DREQ;
  logic       DACK;
  logic       IOR_N;
  logic       IOW_N;
  logic       EOP_N;
  logic [7:0] DB_IN;
  logic [7:0] DB_OUT;
  logic       DB_OE;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;

  modport slave (
    output DREQ, DB_OUT, DB_OE, wr_ready, rd_valid, rd_data,
    input  DACK, IOR_N, IOW_N, EOP_N, DB_IN, wr_valid, wr_data, rd_ready
  );

  modport master (
    input  DREQ, DB_OUT, DB_OE, wr_ready, rd_valid, rd_data,
    output DACK, IOR_N, IOW_N, EOP_N, DB_IN, wr_valid, wr_data, rd_ready
  );
endinterface

// File: rtl/dma_dreq_agent.sv
// Device-side DREQ/DACK agent for one 8237-style DMA channel: a byte FIFO between
// the local datapath and the bus, request generation, strobe handling and error flags.
module dma_dreq_agent #(
  parameter int DEPTH  = 16,
  parameter int THRESH = 4
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            ENABLE,
  input  logic            DIR,
  input  logic [1:0]      MODE,
  input  logic            DREQ_POL,
  input  logic            DACK_POL,
  output logic            done,
  output logic            underrun,
  output logic            overrun,
  dma_dreq_agent_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  typedef enum logic [1:0] {IDLE, REQ, ACKED} state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          ior_q, iow_q, eop_q, dack_act_q;
  logic          ior_prev_q, iow_prev_q;
  logic          ior_act_q, ior_act_d;
  logic          ior_under_q, ior_under_d;
  logic          iow_act_q, iow_act_d;
  logic [7:0]    db_in_q, db_in_d;
  logic [7:0]    db_out_q, db_out_d;
  logic          db_oe_q, db_oe_d;
  logic          done_q, done_d;
  logic          underrun_q, underrun_d;
  logic          overrun_q, overrun_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem [DEPTH];

  logic          empty, full, mode_single, mode_demand, cond;
  logic [CW-1:0] free, need;
  logic          ior_fall, ior_rise, iow_fall, iow_rise;
  logic          eop_hit, start_ok, strobe_done;
  logic          bus_push, bus_pop, loc_push, loc_pop, push, pop;
  logic [7:0]    push_data;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign free        = DEPTH_C - count_q;
  // MODE 01 and the reserved 11 both behave as single transfer
  assign mode_single = MODE[0];
  assign mode_demand = (MODE == 2'b00);
  assign need        = mode_single ? CW'(1) : THRESH_C;
  assign cond        = ENABLE && !done_q && (DIR ? (free >= need) : (count_q >= need));

  assign ior_fall    = ior_prev_q && !ior_q;
  assign ior_rise    = !ior_prev_q && ior_q;
  assign iow_fall    = iow_prev_q && !iow_q;
  assign iow_rise    = !iow_prev_q && iow_q;
  assign eop_hit     = !eop_q && dack_act_q;
  assign start_ok    = (state_q == ACKED) && dack_act_q && !eop_hit && ENABLE;
  assign strobe_done = (ior_act_q && ior_rise) || (iow_act_q && iow_rise);

  assign bus_pop     = ior_act_q && ior_rise && !ior_under_q;
  assign bus_push    = iow_act_q && iow_rise && !full;
  assign loc_push    = bus.wr_valid && bus.wr_ready;
  assign loc_pop     = bus.rd_valid && bus.rd_ready;
  assign push        = DIR ? bus_push : loc_push;
  assign pop         = DIR ? loc_pop : bus_pop;
  assign push_data   = DIR ? db_in_q : bus.wr_data;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ior_act_d   = ior_act_q;
    ior_under_d = ior_under_q;
    iow_act_d   = iow_act_q;
    db_in_d     = db_in_q;
    db_out_d    = db_out_q;
    db_oe_d     = db_oe_q;
    done_d      = done_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);

    if (!bus.IOW_N) db_in_d = bus.DB_IN;

    // Strobes finish regardless of state, so an in-flight cycle survives EOP or ENABLE=0
    if (ior_act_q) begin
      if (ior_rise) begin
        ior_act_d = 1'b0;
        db_oe_d   = 1'b0;
      end
    end else if (ior_fall && start_ok && !DIR) begin
      ior_act_d   = 1'b1;
      ior_under_d = empty;
      db_oe_d     = 1'b1;
      db_out_d    = empty ? 8'hFF : mem[rd_ptr_q];
      if (empty) underrun_d = 1'b1;
    end

    if (iow_act_q) begin
      if (iow_rise) begin
        iow_act_d = 1'b0;
        if (full) overrun_d = 1'b1;
      end
    end else if (iow_fall && start_ok && DIR) begin
      iow_act_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cond) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        if (dack_act_q) state_d = ACKED;
      end
      ACKED: begin
        if (mode_single) begin
          if (strobe_done) req_d = 1'b0;
        end else if (mode_demand) begin
          if (DIR ? (count_d == DEPTH_C) : (count_d == '0)) req_d = 1'b0;
        end
        if (!dack_act_q) state_d = req_d ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (eop_hit) begin
      done_d  = 1'b1;
      req_d   = 1'b0;
      state_d = IDLE;
    end

    if (!ENABLE) begin
      req_d      = 1'b0;
      state_d    = IDLE;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      ior_q       <= 1'b1;
      iow_q       <= 1'b1;
      eop_q       <= 1'b1;
      dack_act_q  <= 1'b0;
      ior_prev_q  <= 1'b1;
      iow_prev_q  <= 1'b1;
      ior_act_q   <= 1'b0;
      ior_under_q <= 1'b0;
      iow_act_q   <= 1'b0;
      db_in_q     <= 8'h00;
      db_out_q    <= 8'h00;
      db_oe_q     <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      ior_q       <= bus.IOR_N;
      iow_q       <= bus.IOW_N;
      eop_q       <= bus.EOP_N;
      dack_act_q  <= bus.DACK ^ DACK_POL;
      ior_prev_q  <= ior_q;
      iow_prev_q  <= iow_q;
      ior_act_q   <= ior_act_d;
      ior_under_q <= ior_under_d;
      iow_act_q   <= iow_act_d;
      db_in_q     <= db_in_d;
      db_out_q    <= db_out_d;
      db_oe_q     <= db_oe_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign bus.DREQ     = req_q ^ DREQ_POL;
  assign bus.DB_OUT   = db_out_q;
  assign bus.DB_OE    = db_oe_q;
  assign bus.wr_ready = !full && !DIR;
  assign bus.rd_valid = !empty && DIR;
  assign bus.rd_data  = mem[rd_ptr_q];
  assign done         = done_q;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_dma_dreq_agent.sv
// Self-checking bench for dma_dreq_agent: a request-condition vector table, directed
// multi-cycle sequences, and randomized traffic against a queue-based reference model.
module tb_dma_dreq_agent;
  localparam int DEPTH  = 16;
  localparam int THRESH = 4;

  typedef struct {
    logic       enable;
    logic       dir;
    logic [1:0] mode;
    logic       dreq_pol;
    int         n_push;
    logic       exp_dreq;
    logic       exp_wr_ready;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, dir, dreq_pol, dack_pol;
  logic [1:0] mode;
  logic       done, underrun, overrun;
  int         err_count = 0;
  int         check_count = 0;

  dma_dreq_agent_if bus_if();

  dma_dreq_agent #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .CLK      (clk),
    .RESET_N  (rst_n),
    .ENABLE   (enable),
    .DIR      (dir),
    .MODE     (mode),
    .DREQ_POL (dreq_pol),
    .DACK_POL (dack_pol),
    .done     (done),
    .underrun (underrun),
    .overrun  (overrun),
    .bus      (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleBus();
    bus_if.IOR_N    = 1'b1;
    bus_if.IOW_N    = 1'b1;
    bus_if.EOP_N    = 1'b1;
    bus_if.DB_IN    = 8'h00;
    bus_if.wr_valid = 1'b0;
    bus_if.wr_data  = 8'h00;
    bus_if.rd_ready = 1'b0;
    bus_if.DACK     = dack_pol;
  endtask

  task automatic doReset(input logic en, input logic d, input logic [1:0] m, input logic rp, input logic ap);
    enable   = en;
    dir      = d;
    mode     = m;
    dreq_pol = rp;
    dack_pol = ap;
    idleBus();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic setDack(input logic active);
    bus_if.DACK = active ^ dack_pol;
    repeat (3) @(negedge clk);
  endtask

  task automatic pushLocal(input logic [7:0] data);
    bus_if.wr_valid = 1'b1;
    bus_if.wr_data  = data;
    @(negedge clk);
    bus_if.wr_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic popLocal();
    bus_if.rd_ready = 1'b1;
    @(negedge clk);
    bus_if.rd_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic iorPulse(output logic [7:0] seen_data, output logic seen_oe);
    bus_if.IOR_N = 1'b0;
    repeat (3) @(negedge clk);
    seen_data = bus_if.DB_OUT;
    seen_oe   = bus_if.DB_OE;
    bus_if.IOR_N = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic iowPulse(input logic [7:0] data);
    bus_if.DB_IN = data;
    bus_if.IOW_N = 1'b0;
    repeat (3) @(negedge clk);
    bus_if.IOW_N = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    doReset(v.enable, v.dir, v.mode, v.dreq_pol, 1'b0);
    for (int i = 0; i < v.n_push; i++) pushLocal(8'(i));
    repeat (2) @(negedge clk);
    checkOutput($sformatf("vec%0d dreq", idx), bus_if.DREQ, v.exp_dreq);
    checkOutput($sformatf("vec%0d wr_ready", idx), bus_if.wr_ready, v.exp_wr_ready);
  endtask

  vec_t       vecs[13];
  logic [7:0] q[$];
  logic [7:0] seen_d, d;
  logic       seen_oe, served, drained, und_m, ovr_m, exp_v;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 0,  1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 3,  1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 4,  1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 2'b01, 1'b0, 1,  1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1,  1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 2'b10, 1'b0, 3,  1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 2'b10, 1'b1, 5,  1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 1'b1, 2,  1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 2'b01, 1'b0, 2,  1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 2'b10, 1'b0, 0,  1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'b00, 1'b1, 0,  1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 2'b01, 1'b1, 0,  1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'b00, 1'b0, 16, 1'b1, 1'b0};

    // reset values with active-low DREQ: pin must sit at the inactive level
    enable = 1'b1; dir = 1'b0; mode = 2'b00; dreq_pol = 1'b1; dack_pol = 1'b0;
    idleBus();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset dreq", bus_if.DREQ, 1'b1);
    checkOutput("reset db_oe", bus_if.DB_OE, 1'b0);
    checkOutput("reset db_out", bus_if.DB_OUT, 8'h00);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset underrun", underrun, 1'b0);
    checkOutput("reset overrun", overrun, 1'b0);

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

    // demand source: four bytes drained by four reads, then one read too many
    doReset(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pushLocal(8'hA0 + 8'(i));
    checkOutput("seq1 dreq before dack", bus_if.DREQ, 1'b1);
    setDack(1'b1);
    for (int i = 0; i < 4; i++) begin
      iorPulse(seen_d, seen_oe);
      checkOutput($sformatf("seq1 db_out%0d", i), seen_d, 8'hA0 + 8'(i));
      checkOutput($sformatf("seq1 db_oe%0d", i), seen_oe, 1'b1);
      checkOutput($sformatf("seq1 dreq after read%0d", i), bus_if.DREQ, (i == 3) ? 1'b0 : 1'b1);
    end
    checkOutput("seq1 db_oe idle", bus_if.DB_OE, 1'b0);
    checkOutput("seq1 underrun clear", underrun, 1'b0);
    iorPulse(seen_d, seen_oe);
    checkOutput("underrun db_out", seen_d, 8'hFF);
    checkOutput("underrun flag", underrun, 1'b1);

    // single mode, both polarities inverted
    doReset(1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
    pushLocal(8'h51);
    pushLocal(8'h52);
    checkOutput("seq2 dreq active", bus_if.DREQ, 1'b0);
    setDack(1'b1);
    iorPulse(seen_d, seen_oe);
    checkOutput("seq2 db_out", seen_d, 8'h51);
    checkOutput("seq2 dreq released", bus_if.DREQ, 1'b1);
    setDack(1'b0);
    @(negedge clk);
    checkOutput("seq2 dreq reasserted", bus_if.DREQ, 1'b0);

    // block sink terminated by EOP
    doReset(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    checkOutput("seq3 dreq start", bus_if.DREQ, 1'b1);
    setDack(1'b1);
    iowPulse(8'h11);
    iowPulse(8'h22);
    iowPulse(8'h33);
    checkOutput("seq3 dreq held", bus_if.DREQ, 1'b1);
    bus_if.EOP_N = 1'b0;
    repeat (2) @(negedge clk);
    bus_if.EOP_N = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("seq3 done", done, 1'b1);
    checkOutput("seq3 dreq after eop", bus_if.DREQ, 1'b0);
    setDack(1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("seq3 rd_valid%0d", i), bus_if.rd_valid, 1'b1);
      checkOutput($sformatf("seq3 rd_data%0d", i), bus_if.rd_data, 8'h11 * 8'(i + 1));
      popLocal();
    end
    checkOutput("seq3 rd_valid empty", bus_if.rd_valid, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("seq3 no new dreq", bus_if.DREQ, 1'b0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("seq3 done cleared", done, 1'b0);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("seq3 dreq after reenable", bus_if.DREQ, 1'b1);

    // demand sink filled to DEPTH, then one extra write
    doReset(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    setDack(1'b1);
    for (int i = 0; i < DEPTH; i++) iowPulse(8'h40 + 8'(i));
    checkOutput("ovr dreq at full", bus_if.DREQ, 1'b0);
    checkOutput("ovr flag clear", overrun, 1'b0);
    iowPulse(8'hEE);
    checkOutput("ovr flag", overrun, 1'b1);
    setDack(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("ovr rd_data%0d", i), bus_if.rd_data, 8'h40 + 8'(i));
      popLocal();
    end
    checkOutput("ovr count stayed at depth", bus_if.rd_valid, 1'b0);

    // local push lands on the same edge as the bus pop with five bytes buffered
    doReset(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) pushLocal(8'hB0 + 8'(i));
    setDack(1'b1);
    bus_if.IOR_N = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("simul db_out", bus_if.DB_OUT, 8'hB0);
    bus_if.IOR_N = 1'b1;
    @(negedge clk);
    checkOutput("simul wr_ready", bus_if.wr_ready, 1'b1);
    bus_if.wr_valid = 1'b1;
    bus_if.wr_data  = 8'hB5;
    @(negedge clk);
    bus_if.wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      iorPulse(seen_d, seen_oe);
      checkOutput($sformatf("simul drain%0d", i), seen_d, 8'hB0 + 8'(i));
    end
    iorPulse(seen_d, seen_oe);
    checkOutput("simul count was five", seen_d, 8'hFF);

    // asynchronous reset in the middle of a read strobe
    doReset(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pushLocal(8'hC0 + 8'(i));
    setDack(1'b1);
    bus_if.IOR_N = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst db_oe before", bus_if.DB_OE, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst db_oe", bus_if.DB_OE, 1'b0);
    checkOutput("midrst dreq", bus_if.DREQ, 1'b0);
    @(negedge clk);
    bus_if.IOR_N = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // randomized demand source with DACK held granted
    doReset(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    setDack(1'b1);
    q.delete();
    served = 1'b0; drained = 1'b0; und_m = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        if (q.size() < DEPTH) begin
          d = 8'($urandom);
          pushLocal(d);
          q.push_back(d);
          if (q.size() >= THRESH) served = 1'b1;
        end else begin
          checkOutput("r1 wr_ready full", bus_if.wr_ready, 1'b0);
        end
      end else begin
        iorPulse(seen_d, seen_oe);
        if (served) begin
          checkOutput("r1 db_oe", seen_oe, 1'b1);
          if (q.size() == 0) begin
            checkOutput("r1 underrun data", seen_d, 8'hFF);
            und_m = 1'b1;
          end else begin
            checkOutput("r1 data", seen_d, q.pop_front());
            if (q.size() == 0) drained = 1'b1;
          end
        end else begin
          checkOutput("r1 ignored strobe", seen_oe, 1'b0);
        end
      end
      checkOutput("r1 dreq", bus_if.DREQ, served && !drained);
      checkOutput("r1 underrun", underrun, und_m);
    end

    // randomized block sink, inverted polarities
    doReset(1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
    setDack(1'b1);
    q.delete();
    ovr_m = 1'b0;
    for (int k = 0; k < 70; k++) begin
      if ($urandom_range(0, 9) < 7) begin
        d = 8'($urandom);
        iowPulse(d);
        if (q.size() == DEPTH) ovr_m = 1'b1;
        else q.push_back(d);
      end else begin
        exp_v = (q.size() > 0);
        checkOutput("r2 rd_valid", bus_if.rd_valid, exp_v);
        if (exp_v) checkOutput("r2 rd_data", bus_if.rd_data, q[0]);
        popLocal();
        if (exp_v) void'(q.pop_front());
      end
      checkOutput("r2 dreq", bus_if.DREQ, 1'b0);
      checkOutput("r2 overrun", overrun, ovr_m);
    end

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end
endmodule
